instr_prefetch_buffer: RTL and testbench

INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

---
 rtl/arm_pipe_pkg.sv | 20 ++
 rtl/prefetch_fifo.sv | 69 ++++++
 rtl/instr_prefetch_buffer.sv | 164 ++++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : arm_pipe_pkg
//  Description : Shared constants and types for the instruction fetch path.
//  Revision    : 1.0 - initial release
// ============================================================================
package arm_pipe_pkg;

    localparam int WORD_W      = 32;
    localparam int INSTR_BYTES = 4;

    // Prefetch control states: RUN fetches, DRAIN swallows stale responses
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

endpackage : arm_pipe_pkg
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : prefetch_fifo
//  Description : Synchronous FIFO holding {address, instruction} pairs.
//                Head is presented combinationally; reads zero when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Flush wins over push/pop; pop of an empty FIFO is ignored
    assign w_do_push = i_push && !i_flush;
    assign w_do_pop  = i_pop && !i_flush && (r_count != '0);

    // Pointer and occupancy tracking; pointers wrap since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because reads are masked when empty
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_empty   = (r_count == '0);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule : prefetch_fifo
`default_nettype wire

// File: rtl/instr_prefetch_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : instr_prefetch_buffer
//  Description : Credit-limited instruction prefetcher. Issues sequential
//                word fetches, buffers responses with their PCs, and on a
//                core redirect flushes and drains stale in-flight responses.
//                Optional feature macro: PREFETCH_PERF_CNT_EN adds the
//                o_StarveCnt / o_RedirectCnt performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch_buffer
    import arm_pipe_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        i_Redirect,
    input  logic [31:0] i_RedirectAddr,
    input  logic        i_Stall,
    output logic [31:0] o_Instr,
    output logic [31:0] o_PC,
    output logic        o_Valid,
    output logic        o_ReqValid,
    output logic [31:0] o_ReqAddr,
    input  logic        i_ReqReady,
    input  logic        i_RspValid,
    input  logic [31:0] i_RspData
`ifdef PREFETCH_PERF_CNT_EN
    ,
    output logic [31:0] o_StarveCnt,
    output logic [31:0] o_RedirectCnt
`endif
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam int          CW1     = CW + 1;
    localparam logic [CW:0] c_DEPTH = CW1'(DEPTH);
    localparam logic [31:0] c_STEP  = 32'(INSTR_BYTES);

    fetch_state_e          r_state;
    fetch_state_e          w_next_state;
    logic [WORD_W-1:0]     r_fetch_addr;
    logic [WORD_W-1:0]     r_rsp_addr;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_drop_cnt;
    logic [CW-1:0]         w_out_next;
    logic [CW-1:0]         w_fifo_count;
    logic [CW:0]           w_inflight;
    logic                  w_credit;
    logic                  w_accept;
    logic                  w_rsp;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [2*WORD_W-1:0]   w_head;
    logic [WORD_W-1:0]     w_target;

    // Occupancy-based credit: never request more than the FIFO can absorb
    assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign w_credit   = (w_inflight < c_DEPTH);
    assign w_accept   = o_ReqValid && i_ReqReady;
    assign w_rsp      = i_RspValid && (r_outstanding != '0);
    assign w_target   = {i_RedirectAddr[31:2], 2'b00};

    // Outstanding count after this cycle's accept and response
    always_comb begin
        w_out_next = r_outstanding;
        case ({w_accept, w_rsp})
            2'b10:   w_out_next = r_outstanding + CW'(1);
            2'b01:   w_out_next = r_outstanding - CW'(1);
            default: w_out_next = r_outstanding;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_next_state;
    end

    // Next-state: redirect drains whatever remains in flight; drain ends on last drop
    always_comb begin
        w_next_state = r_state;
        if (i_Redirect) begin
            w_next_state = (w_out_next != '0) ? ST_DRAIN : ST_RUN;
        end else if (r_state == ST_DRAIN && w_rsp && r_drop_cnt == CW'(1)) begin
            w_next_state = ST_RUN;
        end
    end

    // State outputs: request only when running with credit; enqueue only live data
    always_comb begin
        o_ReqValid = rst_n && (r_state == ST_RUN) && w_credit;
        w_push     = w_rsp && (r_state == ST_RUN) && !i_Redirect;
    end

    // Fetch/response addresses, outstanding and drop bookkeeping
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_addr  <= RESET_PC;
            r_rsp_addr    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (i_Redirect) begin
                r_fetch_addr <= w_target;
                r_rsp_addr   <= w_target;
                r_drop_cnt   <= w_out_next;
            end else begin
                if (w_accept) r_fetch_addr <= r_fetch_addr + c_STEP;
                if (w_push)   r_rsp_addr   <= r_rsp_addr + c_STEP;
                if (r_state == ST_DRAIN && w_rsp) r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    assign o_ReqAddr = r_fetch_addr;
    assign o_Valid   = !w_empty && !i_Redirect;
    assign w_pop     = o_Valid && !i_Stall;
    assign o_PC      = w_head[2*WORD_W-1:WORD_W];
    assign o_Instr   = w_head[WORD_W-1:0];

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*WORD_W)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (rst_n),
        .i_flush   (i_Redirect),
        .i_push    (w_push),
        .i_wr_data ({r_rsp_addr, i_RspData}),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_empty   (w_empty),
        .o_count   (w_fifo_count)
    );

`ifdef PREFETCH_PERF_CNT_EN
    logic [31:0] r_starve_cnt;
    logic [31:0] r_redirect_cnt;

    // Saturating counters for core starvation cycles and redirects
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt   <= '0;
            r_redirect_cnt <= '0;
        end else begin
            if (!o_Valid && !i_Stall && !i_Redirect && r_starve_cnt != '1)
                r_starve_cnt <= r_starve_cnt + 32'd1;
            if (i_Redirect && r_redirect_cnt != '1)
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end
    end

    assign o_StarveCnt   = r_starve_cnt;
    assign o_RedirectCnt = r_redirect_cnt;
`endif

endmodule : instr_prefetch_buffer
`default_nettype wire

// File: tb/tb_instr_prefetch_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_instr_prefetch_buffer
//  Description : Directed self-checking bench for instr_prefetch_buffer with
//                a latency-programmable in-order instruction memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_buffer;

    localparam logic [31:0] c_KEY = 32'h1357_9BDF;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_Redirect = 1'b0;
    logic [31:0] i_RedirectAddr = '0;
    logic        i_Stall = 1'b0;
    logic [31:0] o_Instr;
    logic [31:0] o_PC;
    logic        o_Valid;
    logic        o_ReqValid;
    logic [31:0] o_ReqAddr;
    logic        i_ReqReady = 1'b1;
    logic        i_RspValid = 1'b0;
    logic [31:0] i_RspData = '0;
`ifdef PREFETCH_PERF_CNT_EN
    logic [31:0] o_StarveCnt;
    logic [31:0] o_RedirectCnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .CLK            (CLK),
        .rst_n          (rst_n),
        .i_Redirect     (i_Redirect),
        .i_RedirectAddr (i_RedirectAddr),
        .i_Stall        (i_Stall),
        .o_Instr        (o_Instr),
        .o_PC           (o_PC),
        .o_Valid        (o_Valid),
        .o_ReqValid     (o_ReqValid),
        .o_ReqAddr      (o_ReqAddr),
        .i_ReqReady     (i_ReqReady),
        .i_RspValid     (i_RspValid),
        .i_RspData      (i_RspData)
`ifdef PREFETCH_PERF_CNT_EN
        ,
        .o_StarveCnt    (o_StarveCnt),
        .o_RedirectCnt  (o_RedirectCnt)
`endif
    );

    always #5 CLK = ~CLK;

    // ---------------- memory model and monitors ----------------
    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; int cyc; } dlv_t;

    req_t        pend[$];
    logic [31:0] req_log[$];
    dlv_t        dlv[$];
    int          edge_no = 0;
    int          lat = 1;

    initial forever begin
        @(posedge CLK);
        edge_no++;
    end

    // In-order memory: a request accepted at edge e returns for sampling at edge e+lat
    initial forever begin
        @(negedge CLK);
        #1;
        if (!rst_n) begin
            pend.delete();
            i_RspValid = 1'b0;
            i_RspData  = '0;
        end else begin
            if (pend.size() > 0 && pend[0].due <= edge_no + 1) begin
                i_RspValid = 1'b1;
                i_RspData  = pend[0].addr ^ c_KEY;
                void'(pend.pop_front());
            end else begin
                i_RspValid = 1'b0;
                i_RspData  = '0;
            end
            if (o_ReqValid && i_ReqReady) begin
                pend.push_back('{o_ReqAddr, edge_no + 1 + lat});
                req_log.push_back(o_ReqAddr);
            end
        end
    end

    // Record every instruction the core consumes
    initial forever begin
        @(negedge CLK);
        #2;
        if (rst_n && o_Valid && !i_Stall)
            dlv.push_back('{o_PC, o_Instr, edge_no});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (i >= 0 && i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] dlv_pc(input int i);
        return (i >= 0 && i < dlv.size()) ? dlv[i].pc : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] dlv_instr(input int i);
        return (i >= 0 && i < dlv.size()) ? dlv[i].instr : 32'hDEAD_BEEF;
    endfunction

    function automatic int dlv_cyc(input int i);
        return (i >= 0 && i < dlv.size()) ? dlv[i].cyc : -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Hold reset for two cycles, then release on a falling edge with clean logs
    task automatic do_reset(input int l, input logic rdy, input logic stall);
        @(negedge CLK);
        rst_n = 1'b0;
        i_Redirect = 1'b0;
        i_RedirectAddr = '0;
        i_Stall = stall;
        i_ReqReady = rdy;
        lat = l;
        tick(2);
        req_log.delete();
        dlv.delete();
        rst_n = 1'b1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int base;
        int idx;

        // Reset state
        #2;
        check_val("rst_valid", o_Valid, 0);
        check_val("rst_reqvalid", o_ReqValid, 0);
        check_val("rst_instr", o_Instr, 0);
        check_val("rst_pc", o_PC, 0);
        check_val("rst_reqaddr", o_ReqAddr, 0);

        // Streaming with latency 1: first instruction two cycles after release
        do_reset(1, 1'b1, 1'b0);
        base = edge_no;
        #2;
        check_val("t1_reqvalid", o_ReqValid, 1);
        check_val("t1_reqaddr", o_ReqAddr, 32'h0);
        check_val("t1_valid0", o_Valid, 0);
        tick(8);
        for (int k = 0; k < 4; k++)
            check_val("t1_req", log_at(k), 32'(4 * k));
        for (int k = 0; k < 5; k++) begin
            check_val("t1_pc", dlv_pc(k), 32'(4 * k));
            check_val("t1_instr", dlv_instr(k), 32'(4 * k) ^ c_KEY);
            check_val("t1_cyc", 32'(dlv_cyc(k)), 32'(base + 2 + k));
        end
`ifdef PREFETCH_PERF_CNT_EN
        check_val("t1_starve", o_StarveCnt, 32'd2);
        check_val("t1_redircnt", o_RedirectCnt, 32'd0);
`endif

        // Stall held: exactly DEPTH requests, then in-order drain and resume at 0x10
        do_reset(1, 1'b1, 1'b1);
        tick(10);
        #2;
        check_val("t2_nreq", 32'(req_log.size()), 32'd4);
        check_val("t2_reqvalid", o_ReqValid, 0);
        check_val("t2_valid", o_Valid, 1);
        check_val("t2_headpc", o_PC, 32'h0);
        check_val("t2_ndlv", 32'(dlv.size()), 32'd0);
        @(negedge CLK);
        i_Stall = 1'b0;
        tick(8);
        for (int k = 0; k < 5; k++)
            check_val("t2_pc", dlv_pc(k), 32'(4 * k));
        check_val("t2_resume", log_at(4), 32'h10);

        // Latency 3, redirect with two outstanding: drain then fetch 0x100
        do_reset(3, 1'b1, 1'b0);
        tick(2);
        i_ReqReady = 1'b0;
        i_Redirect = 1'b1;
        i_RedirectAddr = 32'h100;
        #2;
        check_val("t3_valid_redir", o_Valid, 0);
        @(negedge CLK);
        i_Redirect = 1'b0;
        i_ReqReady = 1'b1;
        #2;
        check_val("t3_drain_req0", o_ReqValid, 0);
        tick(1);
        #2;
        check_val("t3_drain_req1", o_ReqValid, 0);
        tick(1);
        #2;
        check_val("t3_run_req", o_ReqValid, 1);
        check_val("t3_run_addr", o_ReqAddr, 32'h100);
        tick(8);
        check_val("t3_nreq_pre", log_at(1), 32'h4);
        check_val("t3_req_target", log_at(2), 32'h100);
        check_val("t3_first_pc", dlv_pc(0), 32'h100);
        check_val("t3_first_instr", dlv_instr(0), 32'h100 ^ c_KEY);
`ifdef PREFETCH_PERF_CNT_EN
        check_val("t3_redircnt", o_RedirectCnt, 32'd1);
`endif

        // Redirect coinciding with a response: response dropped, refetch at 0x200
        do_reset(1, 1'b1, 1'b1);
        tick(2);
        #2;
        check_val("t4_valid_pre", o_Valid, 1);
        check_val("t4_pc_pre", o_PC, 32'h0);
        i_Redirect = 1'b1;
        i_RedirectAddr = 32'h203;
        #1;
        check_val("t4_valid_redir", o_Valid, 0);
        @(negedge CLK);
        i_Redirect = 1'b0;
        i_Stall = 1'b0;
        #2;
        check_val("t4_drain_req", o_ReqValid, 0);
        tick(6);
        check_val("t4_req_target", log_at(3), 32'h200);
        check_val("t4_first_pc", dlv_pc(0), 32'h200);
        check_val("t4_first_instr", dlv_instr(0), 32'h200 ^ c_KEY);

        // Address wrap at the top of the address space
        do_reset(1, 1'b1, 1'b0);
        tick(3);
        i_Redirect = 1'b1;
        i_RedirectAddr = 32'hFFFF_FFF8;
        @(negedge CLK);
        i_Redirect = 1'b0;
        dlv.delete();
        tick(8);
        idx = -1;
        for (int k = req_log.size() - 1; k >= 0; k--)
            if (req_log[k] == 32'hFFFF_FFF8) idx = k;
        check_val("t5_found", 32'(idx >= 0), 32'd1);
        check_val("t5_req1", (idx >= 0) ? log_at(idx + 1) : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check_val("t5_req2", (idx >= 0) ? log_at(idx + 2) : 32'hDEAD_BEEF, 32'h0000_0000);
        check_val("t5_pc0", dlv_pc(0), 32'hFFFF_FFF8);
        check_val("t5_pc1", dlv_pc(1), 32'hFFFF_FFFC);
        check_val("t5_pc2", dlv_pc(2), 32'h0000_0000);

        // Asynchronous reset in the middle of a drain
        do_reset(3, 1'b1, 1'b0);
        tick(2);
        i_ReqReady = 1'b0;
        i_Redirect = 1'b1;
        i_RedirectAddr = 32'h100;
        @(negedge CLK);
        i_Redirect = 1'b0;
        i_ReqReady = 1'b1;
        #2;
        check_val("t6_pre_addr", o_ReqAddr, 32'h100);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("t6_reqvalid", o_ReqValid, 0);
        check_val("t6_reqaddr", o_ReqAddr, 32'h0);
        check_val("t6_valid", o_Valid, 0);
        check_val("t6_instr", o_Instr, 0);
        check_val("t6_pc", o_PC, 0);
        tick(2);
        req_log.delete();
        dlv.delete();
        rst_n = 1'b1;
        #2;
        check_val("t6_rel_req", o_ReqValid, 1);
        check_val("t6_rel_addr", o_ReqAddr, 32'h0);
`ifdef PREFETCH_PERF_CNT_EN
        check_val("t6_starve", o_StarveCnt, 32'd0);
        check_val("t6_redircnt", o_RedirectCnt, 32'd0);
`endif
        tick(8);
        check_val("t6_first_req", log_at(0), 32'h0);
        check_val("t6_first_pc", dlv_pc(0), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_instr_prefetch_buffer
`default_nettype wire
